imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 5, instruction-memory address width (32 words).
REQ-002 Parameter DEPTH, default 32, maximum number of words per image.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low (rst=0 resets).
REQ-005 start  input  1  one-cycle pulse that begins an image load.
REQ-006 len  input  6  word count of the image, sampled on an accepted start.
REQ-007 byte_valid  input  1  upstream byte available.
REQ-008 byte_data  input  8  upstream byte.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-011 wr_addr  output  ADDR_W  word address for the write.
REQ-012 wr_data  output  32  word to write.
REQ-013 cpu_clr  output  1  holds the processor program counter cleared while high.
REQ-014 done  output  1  image loaded and checksum valid.
REQ-015 err  output  1  load aborted (bad len or checksum mismatch).

Function
REQ-016 Byte transfer SHALL occur only in a cycle where byte_valid=1 and byte_ready=1.
REQ-017 FSM states SHALL be IDLE, LOAD, WRITE, CHECK, DONE, ERR.
REQ-018 IDLE: byte_ready=0, cpu_clr=1; start=1 -> LOAD if 1<=len<=DEPTH, else ERR.
REQ-019 LOAD: byte_ready=1; bytes are packed little-endian (1st byte -> wr_data[7:0], 4th -> [31:24]).
REQ-020 After the 4th byte of a word is accepted, the next cycle SHALL be WRITE: wr_en=1, wr_addr=word index (0 first), byte_ready=0.
REQ-021 WRITE -> LOAD when the word index is below len-1; otherwise -> CHECK; the word index increments on leaving WRITE.
REQ-022 A running XOR of every accepted image byte SHALL be kept, cleared on an accepted start.
REQ-023 CHECK: byte_ready=1; the accepted byte is compared with the running XOR: equal -> DONE, unequal -> ERR.
REQ-024 DONE: done=1, cpu_clr=0, byte_ready=0; start=1 SHALL restart the load as in IDLE.
REQ-025 ERR: err=1, cpu_clr=1, byte_ready=0; start=1 SHALL restart the load as in IDLE.
REQ-026 Start SHALL be ignored in LOAD, WRITE and CHECK.
REQ-027 done and err SHALL never be high together; wr_en SHALL be high only in WRITE.
REQ-028 An accepted start SHALL clear done, err, the word index and the byte counter in the same edge.
REQ-029 byte_valid held low SHALL stall LOAD/CHECK indefinitely with no state change; no timeout.
REQ-030 len=DEPTH SHALL write addresses 0..DEPTH-1 with no wrap; the index never exceeds len-1.

Reset
REQ-031 rst=0 SHALL force state IDLE, all counters and the XOR to 0, wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, done=0, err=0, cpu_clr=1, at any point including mid-load.
REQ-032 After rst deasserts, the first start is honoured on the following clock edge.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the constants ADDR_W=5, DEPTH=32 and BYTES_PER_WORD=4.
REQ-034 Byte packing SHALL be a sub-module, byte_packer: 2-bit byte counter plus a 32-bit shift/assembly register with a word_full flag.

Verification
REQ-035 len=1; bytes 33,E2,62,00 and checksum B3 -> one wr_en, addr 0, data 0062E233; then done=1, cpu_clr=0.
REQ-036 len=2; words 00000001 and 00000002 with a wrong checksum of 00 -> two writes (addr 0, 1); then err=1, cpu_clr=1.
REQ-037 start with len=0, and separately with len=33 -> ERR the next cycle; no wr_en.
REQ-038 len=32, byte_valid toggled randomly -> 32 writes at addresses 0..31 in order; done=1 after a correct checksum.
REQ-039 rst=0 after 2 of 3 words are written -> all outputs at reset values immediately; a fresh start reloads from addr 0.
REQ-040 start pulsed during LOAD and while in DONE -> ignored in LOAD; restarts from DONE with done cleared.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction-memory loader
package imem_loader_pkg;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 32;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles little-endian 32-bit words from a byte stream
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0] cnt;
  // high in the cycle whose accepted byte completes the word
  assign word_full = en && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
      word <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams an image of len words into instruction memory, then verifies an XOR checksum byte
module imem_loader #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W,
  parameter int DEPTH = imem_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_clr,
  output logic              done,
  output logic              err
);
  import imem_loader_pkg::*;
  state_t state, nxt;
  logic [5:0] len_q;
  logic [7:0] csum;
  logic [ADDR_W-1:0] idx;
  logic go, acc, more, full;
  assign go = start && (state == IDLE || state == DONE || state == ERR);
  assign acc = byte_valid && byte_ready;
  assign more = 6'(idx) < len_q - 6'd1;
  assign wr_addr = idx;
  imem_loader_byte_packer byte_packer (
    .clk(clk), .rst(rst), .clr(go), .en(acc && state == LOAD),
    .din(byte_data), .word(wr_data), .word_full(full)
  );
  always_comb begin
    nxt = state;
    if (go) nxt = (len != 6'd0 && 32'(len) <= DEPTH) ? LOAD : ERR;
    else if (state == LOAD && full) nxt = WRITE;
    else if (state == WRITE) nxt = more ? LOAD : CHECK;
    else if (state == CHECK && acc) nxt = (byte_data == csum) ? DONE : ERR;
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      len_q <= '0;
      csum <= '0;
      idx <= '0;
      byte_ready <= 1'b0;
      wr_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cpu_clr <= 1'b1;
    end else begin
      state <= nxt;
      byte_ready <= nxt == LOAD || nxt == CHECK;
      wr_en <= nxt == WRITE;
      done <= nxt == DONE;
      err <= nxt == ERR;
      cpu_clr <= nxt != DONE;
      if (go) begin
        len_q <= len;
        csum <= '0;
        idx <= '0;
      end else begin
        if (state == LOAD && acc) csum <= csum ^ byte_data;
        if (state == WRITE && more) idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and random-stream checks of imem_loader against a word/checksum model
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int len;
    bit bad;
    int pct;
    bit exp_done;
    bit exp_err;
  } vec_t;

  logic clk = 0, rst = 0, start = 0, byte_valid = 0;
  logic [5:0] len = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, wr_en, cpu_clr, done, err;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  int checks = 0, errors = 0;
  int got_a[$];
  logic [31:0] got_d[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_clr(cpu_clr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got_a.push_back(int'(wr_addr));
      got_d.push_back(wr_data);
    end
    if (rst) begin
      checks++;
      if (done && err) begin
        errors++;
        $display("FAIL done_err_exclusive: done=%0b err=%0b at %0t", done, err, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int l);
    start = 1;
    len = 6'(l);
    tick();
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int pct);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    byte_data = b;
    while (!ok && n < 1000) begin
      byte_valid = $urandom_range(99) < pct;
      ok = byte_valid && byte_ready;
      tick();
      n++;
    end
    byte_valid = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
  endtask

  function automatic logic [7:0] xor_of(input bq_t d);
    logic [7:0] x = 0;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  task automatic load(input int l, input bq_t d, input logic [7:0] ck, input int pct, output int base);
    base = got_a.size();
    pulse(l);
    foreach (d[i]) send(d[i], pct);
    send(ck, pct);
  endtask

  task automatic check_writes(input string tag, input int base, input bq_t d);
    int nw;
    nw = d.size() / 4;
    chk({tag, "_nwrites"}, 32'(got_a.size() - base), 32'(nw));
    for (int w = 0; w < nw && base + w < got_a.size(); w++) begin
      chk({tag, "_addr"}, 32'(got_a[base+w]), 32'(w));
      chk({tag, "_data"}, got_d[base+w], {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]});
    end
  endtask

  task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_cpu_clr"}, 32'(cpu_clr), 32'(!exp_done));
    chk({tag, "_ready"}, 32'(byte_ready), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cpu_clr"}, 32'(cpu_clr), 1);
  endtask

  initial begin
    vec_t tbl[7];
    bq_t d;
    logic [7:0] ck;
    int base;
    tbl[0] = '{len: 1, bad: 0, pct: 100, exp_done: 1, exp_err: 0};
    tbl[1] = '{len: 2, bad: 1, pct: 70, exp_done: 0, exp_err: 1};
    tbl[2] = '{len: 0, bad: 0, pct: 100, exp_done: 0, exp_err: 1};
    tbl[3] = '{len: 33, bad: 0, pct: 100, exp_done: 0, exp_err: 1};
    tbl[4] = '{len: 32, bad: 0, pct: 50, exp_done: 1, exp_err: 0};
    tbl[5] = '{len: 3, bad: 1, pct: 40, exp_done: 0, exp_err: 1};
    tbl[6] = '{len: 7, bad: 0, pct: 85, exp_done: 1, exp_err: 0};

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1;

    d = '{8'h33, 8'hE2, 8'h62, 8'h00};
    load(1, d, 8'hB3, 100, base);
    chk("fixed1_data", got_d.size() > base ? got_d[base] : 32'hx, 32'h0062E233);
    check_writes("fixed1", base, d);
    check_end("fixed1", 1, 0);

    d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    load(2, d, 8'h00, 100, base);
    check_writes("fixed2", base, d);
    check_end("fixed2", 0, 1);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].len < 1 || tbl[v].len > 32) begin
        base = got_a.size();
        pulse(tbl[v].len);
        check_end($sformatf("vec%0d", v), tbl[v].exp_done, tbl[v].exp_err);
        tick();
        tick();
        chk($sformatf("vec%0d_nwrites", v), 32'(got_a.size() - base), 0);
      end else begin
        d = rand_bytes(4 * tbl[v].len);
        ck = xor_of(d) ^ (tbl[v].bad ? 8'h5A : 8'h00);
        load(tbl[v].len, d, ck, tbl[v].pct, base);
        check_writes($sformatf("vec%0d", v), base, d);
        check_end($sformatf("vec%0d", v), tbl[v].exp_done, tbl[v].exp_err);
      end
    end

    d = rand_bytes(12);
    base = got_a.size();
    pulse(3);
    for (int i = 0; i < 8; i++) send(d[i], 100);
    tick();
    chk("midrst_writes_before", 32'(got_a.size() - base), 2);
    #2 rst = 0;
    #1 check_reset_vals("midrst");
    tick();
    rst = 1;
    d = rand_bytes(12);
    load(3, d, xor_of(d), 60, base);
    check_writes("reload", base, d);
    check_end("reload", 1, 0);

    d = rand_bytes(8);
    base = got_a.size();
    pulse(2);
    send(d[0], 100);
    send(d[1], 100);
    start = 1;
    len = 6'd5;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_ready", 32'(byte_ready), 1);
    chk("stall_wr_en", 32'(wr_en), 0);
    chk("stall_done", 32'(done), 0);
    for (int i = 2; i < 8; i++) send(d[i], 100);
    send(xor_of(d), 100);
    check_writes("ignore_start", base, d);
    check_end("ignore_start", 1, 0);
    d = rand_bytes(4);
    base = got_a.size();
    pulse(1);
    chk("restart_done", 32'(done), 0);
    chk("restart_ready", 32'(byte_ready), 1);
    chk("restart_cpu_clr", 32'(cpu_clr), 1);
    foreach (d[i]) send(d[i], 100);
    send(xor_of(d), 100);
    check_writes("restart", base, d);
    check_end("restart", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
